// File: rtl/nic_pkg.sv
// Shared types and helpers for the NIC bus arbiter.
package nic_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } nic_state_t;

    // Index width for n items, never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/nic_rr_arbiter.sv
// Combinational round-robin picker: the first requester after last_grant wins,
// wrapping around to the lowest index.
module nic_rr_arbiter
    import nic_pkg::*;
#(
    parameter int N  = 2,
    parameter int IW = idx_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last_grant,
    output logic [IW-1:0] grant,
    output logic          valid
);

    always_comb begin
        grant = '0;
        valid = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!valid && req[i] && (IW'(i) > last_grant)) begin
                grant = IW'(i);
                valid = 1'b1;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!valid && req[i] && (IW'(i) <= last_grant)) begin
                grant = IW'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/nic_arb.sv
// Single-outstanding bus arbiter from several masters to several slaves, with
// round-robin grant and error completion on unmapped select or slave timeout.
//   state | meaning
//   IDLE  | no transaction; a request seen on this edge is granted and latched
//   BUSY  | latched transaction driven to the slave, waiting for its ack
//   RESP  | one-cycle completion to the granted master
module nic_arb
    import nic_pkg::*;
#(
    parameter int MASTERS_COUNT  = 2,
    parameter int ADDR_SEL_WIDTH = 2,
    parameter int SLAVES_COUNT   = 2 ** ADDR_SEL_WIDTH,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic                                          i_clk,
    input  logic                                          i_reset,
    input  logic [MASTERS_COUNT-1:0]                      i_m_req,
    input  logic [MASTERS_COUNT-1:0][ADDR_SEL_WIDTH-1:0]  i_m_addr_sel,
    input  logic [MASTERS_COUNT-1:0]                      i_m_we,
    input  logic [MASTERS_COUNT-1:0][DATA_WIDTH-1:0]      i_m_wdata,
    output logic [MASTERS_COUNT-1:0][DATA_WIDTH-1:0]      o_m_rdata,
    output logic [MASTERS_COUNT-1:0]                      o_m_ack,
    output logic [MASTERS_COUNT-1:0]                      o_m_err,
    output logic [SLAVES_COUNT-1:0]                       o_slave_sel,
    output logic                                          o_slave_we,
    output logic [DATA_WIDTH-1:0]                         o_slave_wdata,
    input  logic [SLAVES_COUNT-1:0][DATA_WIDTH-1:0]       i_slave_rdata,
    input  logic [SLAVES_COUNT-1:0]                       i_slave_ack
);

    localparam int MIW = idx_width(MASTERS_COUNT);
    localparam int TW  = idx_width(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LOAD = (TIMEOUT_CYCLES > 0) ? TW'(TIMEOUT_CYCLES - 1) : '0;

    nic_state_t state_q, state_d;

    logic [MIW-1:0]            last_q, mst_q, gnt_idx;
    logic                      gnt_valid;
    logic [ADDR_SEL_WIDTH-1:0] gnt_addr;
    logic [SLAVES_COUNT-1:0]   sel_dec, sel_q;
    logic                      we_q;
    logic [DATA_WIDTH-1:0]     wdata_q, slave_rd;
    logic [TW-1:0]             tmo_q;
    logic                      slave_hit, unmapped, tmo_hit, busy_done;

    logic [MASTERS_COUNT-1:0]                 ack_q, err_q;
    logic [MASTERS_COUNT-1:0][DATA_WIDTH-1:0] rdata_q;

    nic_rr_arbiter #(.N(MASTERS_COUNT), .IW(MIW)) u_rr (
        .req        (i_m_req),
        .last_grant (last_q),
        .grant      (gnt_idx),
        .valid      (gnt_valid)
    );

    assign gnt_addr = i_m_addr_sel[gnt_idx];

    always_comb begin
        sel_dec = '0;
        for (int s = 0; s < SLAVES_COUNT; s++) begin
            sel_dec[s] = (gnt_addr == ADDR_SEL_WIDTH'(s));
        end
    end

    // sel_q is one-hot of the target slave, so it also masks ack and read data.
    always_comb begin
        slave_rd = '0;
        for (int s = 0; s < SLAVES_COUNT; s++) begin
            if (sel_q[s]) slave_rd = slave_rd | i_slave_rdata[s];
        end
    end

    assign slave_hit = |(i_slave_ack & sel_q);
    assign unmapped  = ~|sel_q;
    assign tmo_hit   = (TIMEOUT_CYCLES != 0) && (tmo_q == '0);
    assign busy_done = slave_hit || unmapped || tmo_hit;

    always_ff @(posedge i_clk) begin
        if (i_reset) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (gnt_valid) state_d = ST_BUSY;
            ST_BUSY: if (busy_done) state_d = ST_RESP;
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            last_q  <= MIW'(MASTERS_COUNT - 1);
            mst_q   <= '0;
            sel_q   <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            tmo_q   <= '0;
            ack_q   <= '0;
            err_q   <= '0;
            rdata_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (gnt_valid) begin
                        mst_q   <= gnt_idx;
                        sel_q   <= sel_dec;
                        we_q    <= (|sel_dec) ? i_m_we[gnt_idx] : 1'b0;
                        wdata_q <= (|sel_dec) ? i_m_wdata[gnt_idx] : '0;
                        tmo_q   <= TMO_LOAD;
                    end
                end
                ST_BUSY: begin
                    if (busy_done) begin
                        sel_q          <= '0;
                        we_q           <= 1'b0;
                        wdata_q        <= '0;
                        ack_q[mst_q]   <= 1'b1;
                        err_q[mst_q]   <= ~slave_hit;
                        rdata_q[mst_q] <= (slave_hit && !we_q) ? slave_rd : '0;
                    end else if (tmo_q != '0) begin
                        tmo_q <= tmo_q - 1'b1;
                    end
                end
                ST_RESP: begin
                    ack_q   <= '0;
                    err_q   <= '0;
                    rdata_q <= '0;
                    last_q  <= mst_q;
                end
                default: ;
            endcase
        end
    end

    assign o_slave_sel   = sel_q;
    assign o_slave_we    = we_q;
    assign o_slave_wdata = wdata_q;
    assign o_m_ack       = ack_q;
    assign o_m_err       = err_q;
    assign o_m_rdata     = rdata_q;

endmodule

// File: tb/tb_nic_arb.sv
// Bench for nic_arb: directed scenarios with literal expectations plus a long
// randomized run checked every cycle against a transaction-level model.
module tb_nic_arb;

    localparam int M   = 3;
    localparam int AW  = 2;
    localparam int S   = 3;
    localparam int DW  = 32;
    localparam int T   = 15;
    localparam int MIW = 2;
    localparam int SIW = 2;

    logic clk = 1'b0;
    logic rst;
    logic [M-1:0]          m_req;
    logic [M-1:0][AW-1:0]  m_addr;
    logic [M-1:0]          m_we;
    logic [M-1:0][DW-1:0]  m_wdata;
    logic [M-1:0][DW-1:0]  m_rdata;
    logic [M-1:0]          m_ack, m_err;
    logic [S-1:0]          s_sel;
    logic                  s_we;
    logic [DW-1:0]         s_wdata;
    logic [S-1:0][DW-1:0]  s_rdata;
    logic [S-1:0]          s_ack;

    int vectors = 0;
    int miscompares = 0;
    bit check_en = 1'b0;

    always #5 clk = ~clk;

    nic_arb #(
        .MASTERS_COUNT(M), .ADDR_SEL_WIDTH(AW), .SLAVES_COUNT(S),
        .DATA_WIDTH(DW), .TIMEOUT_CYCLES(T)
    ) dut (
        .i_clk(clk), .i_reset(rst),
        .i_m_req(m_req), .i_m_addr_sel(m_addr), .i_m_we(m_we), .i_m_wdata(m_wdata),
        .o_m_rdata(m_rdata), .o_m_ack(m_ack), .o_m_err(m_err),
        .o_slave_sel(s_sel), .o_slave_we(s_we), .o_slave_wdata(s_wdata),
        .i_slave_rdata(s_rdata), .i_slave_ack(s_ack)
    );

    task automatic cmp(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: one transaction at a time, tracked by its age in BUSY.
    bit          md_busy = 0, md_resp = 0, md_we = 0, md_err = 0, md_hit = 0;
    int          md_mst = 0, md_addr = 0, md_last = M - 1, md_age = 0;
    logic [DW-1:0] md_wdata = '0, md_rd = '0;
    logic [S-1:0]         e_sel = '0;
    logic                 e_we = 1'b0;
    logic [DW-1:0]        e_wdata = '0;
    logic [M-1:0]         e_ack = '0, e_err = '0;
    logic [M-1:0][DW-1:0] e_rdata = '0;

    always @(posedge clk) begin
        if (rst) begin
            md_busy = 0;
            md_resp = 0;
            md_last = M - 1;
        end else if (md_resp) begin
            md_resp = 0;
            md_last = md_mst;
        end else if (md_busy) begin
            md_age++;
            md_hit = (md_addr < S) && s_ack[SIW'(md_addr)];
            if (md_addr >= S || md_hit || (T != 0 && md_age >= T)) begin
                md_busy = 0;
                md_resp = 1;
                md_err  = !md_hit;
                md_rd   = (md_hit && !md_we) ? s_rdata[SIW'(md_addr)] : '0;
            end
        end else begin
            for (int k = 1; k <= M; k++) begin
                int c;
                c = (md_last + k) % M;
                if (!md_busy && m_req[MIW'(c)]) begin
                    md_busy  = 1;
                    md_mst   = c;
                    md_addr  = int'(m_addr[MIW'(c)]);
                    md_we    = m_we[MIW'(c)];
                    md_wdata = m_wdata[MIW'(c)];
                    md_age   = 0;
                end
            end
        end
        e_sel = '0; e_we = 1'b0; e_wdata = '0;
        e_ack = '0; e_err = '0; e_rdata = '0;
        if (md_busy && md_addr < S) begin
            e_sel[SIW'(md_addr)] = 1'b1;
            e_we    = md_we;
            e_wdata = md_wdata;
        end
        if (md_resp) begin
            e_ack[MIW'(md_mst)]   = 1'b1;
            e_err[MIW'(md_mst)]   = md_err;
            e_rdata[MIW'(md_mst)] = md_rd;
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            cmp("slave_sel", s_sel, e_sel);
            cmp("slave_we", s_we, e_we);
            cmp("slave_wdata", s_wdata, e_wdata);
            cmp("m_ack", m_ack, e_ack);
            cmp("m_err", m_err, e_err);
            cmp("m_rdata", m_rdata, e_rdata);
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    int  order[$];
    int  when[$];
    int  busy_cnt;
    int  pct;
    bit  pend[M];

    initial begin
        rst = 1'b1; m_req = '0; m_addr = '0; m_we = '0; m_wdata = '0;
        s_rdata = '0; s_ack = '0;
        @(posedge clk);
        #1 check_en = 1'b1;
        tick();
        cmp("rst_ack", m_ack, 0);
        cmp("rst_sel", s_sel, 0);
        cmp("rst_rdata", m_rdata, 0);

        // Read of slave 1 by master 0 with an immediately acking slave.
        rst = 1'b0;
        m_req[0] = 1'b1; m_addr[0] = 2'd1; m_we[0] = 1'b0;
        s_ack = 3'b010; s_rdata[1] = 32'hDEADBEEF;
        tick();
        cmp("rd_sel", s_sel, 3'b010);
        cmp("rd_ack_early", m_ack, 0);
        tick();
        cmp("rd_ack", m_ack, 3'b001);
        cmp("rd_err", m_err, 0);
        cmp("rd_data", m_rdata[0], 32'hDEADBEEF);
        cmp("model_rd_data", e_rdata[0], 32'hDEADBEEF);
        m_req = '0; s_ack = '0;
        tick();
        cmp("rd_done", m_ack, 0);

        // Write to slave 2 with a two-cycle slave.
        m_req[0] = 1'b1; m_addr[0] = 2'd2; m_we[0] = 1'b1; m_wdata[0] = 32'h12345678;
        s_rdata[2] = 32'hFFFFFFFF;
        tick();
        cmp("wr_sel", s_sel, 3'b100);
        cmp("wr_we", s_we, 1);
        cmp("wr_wdata", s_wdata, 32'h12345678);
        tick();
        cmp("wr_sel_hold", s_sel, 3'b100);
        s_ack = 3'b100;
        tick();
        cmp("wr_ack", m_ack, 3'b001);
        cmp("wr_rdata_zero", m_rdata[0], 0);
        cmp("wr_sel_off", s_sel, 0);
        m_req = '0; s_ack = '0;
        tick();

        // Request dropped mid-transaction still completes.
        m_req[0] = 1'b1; m_addr[0] = 2'd1; m_we[0] = 1'b0;
        tick();
        m_req[0] = 1'b0;
        tick();
        tick();
        s_ack = 3'b010; s_rdata[1] = 32'h5A5A0001;
        tick();
        cmp("drop_ack", m_ack, 3'b001);
        cmp("drop_data", m_rdata[0], 32'h5A5A0001);
        s_ack = '0;
        tick();

        // Reset during BUSY, then two masters requesting continuously.
        m_req[1] = 1'b1; m_addr[1] = 2'd0; m_we[1] = 1'b0;
        tick();
        cmp("pre_rst_sel", s_sel, 3'b001);
        rst = 1'b1;
        tick();
        cmp("mid_rst_ack", m_ack, 0);
        cmp("mid_rst_sel", s_sel, 0);
        rst = 1'b0;
        m_req[0] = 1'b1; m_addr[0] = 2'd1; m_we[0] = 1'b0;
        s_ack = 3'b111; s_rdata[0] = 32'h00000A00; s_rdata[1] = 32'h00000B01;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (m_ack != 0) begin
                order.push_back(m_ack == 3'b001 ? 0 : m_ack == 3'b010 ? 1 : m_ack == 3'b100 ? 2 : 9);
                when.push_back(i);
            end
        end
        cmp("rr_count", order.size(), 4);
        for (int k = 0; k < 4; k++) begin
            cmp($sformatf("rr_order%0d", k), (k < order.size()) ? order[k] : 99, k % 2);
            cmp($sformatf("rr_when%0d", k), (k < when.size()) ? when[k] : 99, 1 + 3 * k);
        end
        m_req = '0;
        repeat (4) tick();

        // Unmapped slave select.
        m_req[1] = 1'b1; m_addr[1] = 2'd3; m_we[1] = 1'b0;
        tick();
        cmp("unm_sel", s_sel, 0);
        cmp("unm_ack_early", m_ack, 0);
        tick();
        cmp("unm_ack", m_ack, 3'b010);
        cmp("unm_err", m_err, 3'b010);
        cmp("unm_rdata", m_rdata[1], 0);
        cmp("model_unm_err", e_err, 3'b010);
        m_req = '0; s_ack = '0;
        tick();

        // Silent slave: timeout after the full BUSY budget.
        m_req[0] = 1'b1; m_addr[0] = 2'd0; m_we[0] = 1'b0;
        busy_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (m_ack != 0) break;
            if (s_sel != 0) busy_cnt++;
        end
        cmp("tmo_busy_cycles", busy_cnt, T);
        cmp("tmo_ack", m_ack, 3'b001);
        cmp("tmo_err", m_err, 3'b001);
        cmp("tmo_rdata", m_rdata[0], 0);
        m_req = '0;
        tick();

        // Ack on the last BUSY cycle beats the timeout.
        m_req[0] = 1'b1;
        repeat (T) tick();
        cmp("late_sel", s_sel, 3'b001);
        cmp("late_no_ack", m_ack, 0);
        s_ack = 3'b001; s_rdata[0] = 32'hCAFEF00D;
        tick();
        cmp("late_ack", m_ack, 3'b001);
        cmp("late_err", m_err, 0);
        cmp("late_data", m_rdata[0], 32'hCAFEF00D);
        m_req = '0; s_ack = '0;
        tick();

        // Randomized traffic: busy slaves first, then mostly silent ones.
        for (int m = 0; m < M; m++) pend[m] = 1'b0;
        for (int c = 0; c < 6000; c++) begin
            tick();
            pct = (c < 3000) ? 40 : 4;
            rst = ($urandom_range(0, 199) == 0);
            for (int m = 0; m < M; m++) begin
                if (pend[m] && m_ack[MIW'(m)]) begin
                    pend[m] = 1'b0;
                    m_req[MIW'(m)] = 1'b0;
                end else if (pend[m] && $urandom_range(0, 99) == 0) begin
                    pend[m] = 1'b0;
                    m_req[MIW'(m)] = 1'b0;
                end else if (!pend[m] && $urandom_range(0, 99) < 30) begin
                    pend[m] = 1'b1;
                    m_req[MIW'(m)]   = 1'b1;
                    m_addr[MIW'(m)]  = AW'($urandom_range(0, 3));
                    m_we[MIW'(m)]    = 1'($urandom_range(0, 1));
                    m_wdata[MIW'(m)] = $urandom;
                end
            end
            for (int s = 0; s < S; s++) begin
                s_ack[SIW'(s)]   = ($urandom_range(0, 99) < pct);
                s_rdata[SIW'(s)] = $urandom;
            end
        end
        tick();
        check_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/nic_arb.md
NIC_ARB -- requirements
Module: nic_arb

Interface
REQ-001 Parameter MASTERS_COUNT, default 2: number of master ports, 1..8.
REQ-002 Parameter ADDR_SEL_WIDTH, default 2: slave-select field width.
REQ-003 Parameter SLAVES_COUNT, default 2**ADDR_SEL_WIDTH: mapped slaves, at most 2**ADDR_SEL_WIDTH.
REQ-004 Parameter DATA_WIDTH, default 32: data bus width.
REQ-005 Parameter TIMEOUT_CYCLES, default 15: cycles in BUSY without slave ack before error completion; 0 disables timeout.
REQ-006 i_clk  in  1  sole clock; all state on rising edge.
REQ-007 i_reset  in  1  reset, synchronous, active-high.
REQ-008 i_m_req  in  [MASTERS_COUNT]  per-master request, held until that master's ack.
REQ-009 i_m_addr_sel  in  [MASTERS_COUNT][ADDR_SEL_WIDTH]  target slave index.
REQ-010 i_m_we  in  [MASTERS_COUNT]  1 = write, 0 = read.
REQ-011 i_m_wdata  in  [MASTERS_COUNT][DATA_WIDTH]  write data.
REQ-012 o_m_rdata  out  [MASTERS_COUNT][DATA_WIDTH]  registered read data, valid with o_m_ack.
REQ-013 o_m_ack  out  [MASTERS_COUNT]  one-cycle completion pulse.
REQ-014 o_m_err  out  [MASTERS_COUNT]  error flag, valid only with o_m_ack.
REQ-015 o_slave_sel  out  [SLAVES_COUNT]  registered one-hot slave select.
REQ-016 o_slave_we  out  1  registered write enable of granted transaction.
REQ-017 o_slave_wdata  out  [DATA_WIDTH]  registered write data of granted transaction.
REQ-018 i_slave_rdata  in  [SLAVES_COUNT][DATA_WIDTH]  per-slave read data.
REQ-019 i_slave_ack  in  [SLAVES_COUNT]  per-slave completion.

Function
REQ-020 FSM states IDLE, BUSY, RESP; one transaction in flight at any time.
REQ-021 IDLE: if any i_m_req set, grant one master round-robin starting at (last_grant+1) mod MASTERS_COUNT; latch its index, addr_sel, we, wdata; go BUSY. Otherwise stay IDLE.
REQ-022 BUSY with mapped addr_sel: o_slave_sel one-hot at addr_sel, o_slave_we/o_slave_wdata from latched values; all zero in IDLE and RESP.
REQ-023 BUSY, on edge where i_slave_ack[addr_sel]=1: latch i_slave_rdata[addr_sel] (zero if write), err=0, go RESP.
REQ-024 Acks from non-selected slaves, and all acks outside BUSY, are ignored.
REQ-025 Unmapped addr_sel (>= SLAVES_COUNT): no o_slave_sel bit set; BUSY lasts one cycle, then RESP with err=1, rdata=0.
REQ-026 Timeout counter clears on BUSY entry, counts BUSY cycles; reaching TIMEOUT_CYCLES without ack -> RESP with err=1, rdata=0.
REQ-027 Ack and timeout on the same edge: ack wins, err=0.
REQ-028 RESP: o_m_ack/o_m_err/o_m_rdata driven for granted master only, one cycle; non-granted masters see 0; last_grant updated; go IDLE.
REQ-029 Latency with zero-wait slave: req sampled at edge N, o_slave_sel high N..N+1, o_m_ack high N+1..N+2; max throughput one transaction per 3 cycles.
REQ-030 Master deasserting i_m_req during BUSY does not abort; the transaction completes and ack is still delivered.

Reset
REQ-031 i_reset high at an edge forces IDLE regardless of state, abandons any in-flight transaction without ack, clears timeout counter, sets last_grant = MASTERS_COUNT-1 (master 0 has priority first).
REQ-032 All outputs are 0 during and in the first cycle after reset.

Structure
REQ-033 Package nic_pkg holds the state enum typedef and an index-width helper function (clog2, minimum 1).
REQ-034 Round-robin grant logic is sub-module nic_rr_arbiter (request vector, last grant in; grant index, valid out; combinational).

Verification
REQ-035 Reset then master 0 reads slave 1, slave 1 acks immediately with 0xDEADBEEF -> o_m_ack[0] pulses 2 cycles after req, o_m_rdata[0]=0xDEADBEEF, o_m_err[0]=0.
REQ-036 Both masters request continuously -> grants alternate 0,1,0,1; each ack exactly one cycle; no overlap.
REQ-037 SLAVES_COUNT=3, master 1 targets slave 3 -> o_slave_sel stays 0, ack with err=1, rdata=0.
REQ-038 Slave never acks, TIMEOUT_CYCLES=15 -> ack with err=1 after 15 BUSY cycles; ack on cycle 15 instead -> err=0.
REQ-039 Master 0 write 0x12345678 to slave 2 -> o_slave_we=1, o_slave_wdata=0x12345678, o_slave_sel=4'b0100 for the BUSY duration.
REQ-040 i_reset asserted mid-BUSY -> next cycle IDLE, all outputs 0, no ack issued; master 0 granted first afterwards.
